// File: rtl/regbus_pkg.sv
// Shared definitions for the internal register-bus sequencer: FSM encoding,
// register index names and the external-port index derivation.
package regbus_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_DRIVE = S_DRIVE,
        ST_LATCH = S_LATCH,
        ST_TURN  = S_TURN,
        ST_ERR   = S_ERR
    } state_t;

    // Bus-attached register indices as seen by the decoders
    localparam int REG_B   = 0;
    localparam int REG_C   = 1;
    localparam int REG_D   = 2;
    localparam int REG_E   = 3;
    localparam int REG_H   = 4;
    localparam int REG_L   = 5;
    localparam int REG_A   = 6;
    localparam int REG_TMP = 7;

    localparam int DEFAULT_NUM_REGS = REG_TMP + 1;

    // The external data port sits one past the last register
    function automatic int ext_index(input int num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Index to one-hot enable decoder. Bit N is the external data port; an
// index above N (never decoded in a valid transfer) yields all zeros.
module onehot_decode
    import regbus_pkg::*;
#(
    parameter int N    = DEFAULT_NUM_REGS,
    parameter int IDXW = $clog2(N + 1)
) (
    input  logic [IDXW-1:0] idx,
    input  logic            en,
    output logic [N:0]      onehot
);

    // Set exactly the bit addressed by idx when enabled
    always_comb begin
        onehot = '0;
        for (int i = 0; i <= N; i++) begin
            if (en && (idx == IDXW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbus_sequencer.sv
// Register-to-register transfer sequencer for the shared 8-bit tri-state
// bus. Each beat is DRIVE (source on bus), LATCH (destination captures),
// TURN (bus released), so two drivers never overlap and every driver
// change is separated by an idle bus cycle. Pair moves run two beats.
//
// Handshake: req_ready is high only in IDLE (and never during reset). A
// request transfers on the rising edge where req_valid && req_ready; src,
// dst and pair are captured on that edge. The requester holds req_valid and
// its payload stable until that edge; nothing is queued.
module regbus_sequencer
    import regbus_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int IDXW     = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDXW-1:0]     req_src,
    input  logic [IDXW-1:0]     req_dst,
    input  logic                req_pair,
    output logic [NUM_REGS-1:0] reg_oenable,
    output logic [NUM_REGS-1:0] reg_wenable,
    output logic                ext_oenable,
    output logic                ext_wenable,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          dbg_state
);

    localparam int EXT = ext_index(NUM_REGS);

    state_t          state_q, state_d;
    logic            beat_q, beat_d;
    logic [IDXW-1:0] src_q, dst_q;
    logic            pair_q;

    logic            accept;
    logic            src_in_range, dst_in_range, pair_ok, req_ok;
    logic            oe_en, we_en, done_raw, err_raw;
    logic [IDXW-1:0] cur_src, cur_dst;
    logic [NUM_REGS:0] oe_vec, we_vec;

    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // Request validity: indices up to EXT are addressable; a pair needs two
    // adjacent real registers starting on an even index.
    assign src_in_range = int'(req_src) <= EXT;
    assign dst_in_range = int'(req_dst) <= EXT;
    assign pair_ok      = (int'(req_src) != EXT) && (int'(req_dst) != EXT)
                       && !req_src[0] && !req_dst[0]
                       && ((int'(req_src) + 1) < NUM_REGS)
                       && ((int'(req_dst) + 1) < NUM_REGS);
    assign req_ok       = src_in_range && dst_in_range && (!req_pair || pair_ok);

    // State, beat and captured request; reset abandons any in-flight move
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            pair_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (accept) begin
                src_q  <= req_src;
                dst_q  <= req_dst;
                pair_q <= req_pair;
            end
        end
    end

    // Next state and Moore enables, decoded from state and captured fields only
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        oe_en    = 1'b0;
        we_en    = 1'b0;
        done_raw = 1'b0;
        err_raw  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                beat_d = 1'b0;
                if (accept) begin
                    state_d = req_ok ? ST_DRIVE : ST_ERR;
                end
            end
            ST_DRIVE: begin
                oe_en   = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                oe_en   = 1'b1;
                we_en   = 1'b1;
                state_d = ST_TURN;
            end
            ST_TURN: begin
                if (pair_q && !beat_q) begin
                    beat_d  = 1'b1;
                    state_d = ST_DRIVE;
                end else begin
                    done_raw = 1'b1;
                    beat_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_ERR: begin
                done_raw = 1'b1;
                err_raw  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 1'b0;
            end
        endcase
    end

    // Second beat addresses the odd half of each pair
    assign cur_src = src_q + IDXW'(beat_q);
    assign cur_dst = dst_q + IDXW'(beat_q);

    onehot_decode #(
        .N    (NUM_REGS),
        .IDXW (IDXW)
    ) u_oe_decode (
        .idx    (cur_src),
        .en     (oe_en && rst_n),
        .onehot (oe_vec)
    );

    onehot_decode #(
        .N    (NUM_REGS),
        .IDXW (IDXW)
    ) u_we_decode (
        .idx    (cur_dst),
        .en     (we_en && rst_n),
        .onehot (we_vec)
    );

    assign reg_oenable = oe_vec[NUM_REGS-1:0];
    assign ext_oenable = oe_vec[NUM_REGS];
    assign reg_wenable = we_vec[NUM_REGS-1:0];
    assign ext_wenable = we_vec[NUM_REGS];

    assign busy      = (state_q != ST_IDLE);
    assign done      = rst_n && done_raw;
    assign err       = rst_n && err_raw;
    assign dbg_state = state_q;

endmodule
